// File: rtl/cache_miss_handler_if.sv
// cache_miss_handler_if: miss request, array read, L2 port and fill/pLRU signals of the L1 miss handler
interface cache_miss_handler_if #(
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 24,
    parameter int LINE_W  = 128
);
    logic                     miss_valid_i;
    logic                     miss_ready_o;
    logic [INDEX_W-1:0]       miss_index_i;
    logic [TAG_W-1:0]         miss_tag_i;
    logic [INDEX_W-1:0]       index_o;
    logic [3:0]               way_valid_i;
    logic [3:0]               way_dirty_i;
    logic [1:0]               plru_way_i;
    logic [1:0]               victim_way_o;
    logic [TAG_W-1:0]         victim_tag_i;
    logic [LINE_W-1:0]        victim_data_i;
    logic                     l2_req_valid_o;
    logic                     l2_req_ready_i;
    logic                     l2_req_write_o;
    logic [TAG_W+INDEX_W-1:0] l2_req_addr_o;
    logic [LINE_W-1:0]        l2_req_wdata_o;
    logic                     l2_rsp_valid_i;
    logic [LINE_W-1:0]        l2_rsp_data_i;
    logic                     fill_valid_o;
    logic [TAG_W-1:0]         fill_tag_o;
    logic [LINE_W-1:0]        fill_data_o;
    logic                     plru_valid_o;
    logic [1:0]               plru_way_o;
    logic                     done_o;

    // handler side
    modport master (
        input  miss_valid_i, miss_index_i, miss_tag_i, way_valid_i, way_dirty_i, plru_way_i,
               victim_tag_i, victim_data_i, l2_req_ready_i, l2_rsp_valid_i, l2_rsp_data_i,
        output miss_ready_o, index_o, victim_way_o, l2_req_valid_o, l2_req_write_o,
               l2_req_addr_o, l2_req_wdata_o, fill_valid_o, fill_tag_o, fill_data_o,
               plru_valid_o, plru_way_o, done_o
    );

    // lookup stage, arrays, pLRU and L2 side
    modport slave (
        output miss_valid_i, miss_index_i, miss_tag_i, way_valid_i, way_dirty_i, plru_way_i,
               victim_tag_i, victim_data_i, l2_req_ready_i, l2_rsp_valid_i, l2_rsp_data_i,
        input  miss_ready_o, index_o, victim_way_o, l2_req_valid_o, l2_req_write_o,
               l2_req_addr_o, l2_req_wdata_o, fill_valid_o, fill_tag_o, fill_data_o,
               plru_valid_o, plru_way_o, done_o
    );
endinterface

// File: rtl/cache_miss_handler.sv
// cache_miss_handler: sequences an L1 miss through victim choice, optional writeback, L2 read and fill
module cache_miss_handler #(
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 24,
    parameter int LINE_W  = 128
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    cache_miss_handler_if.master bus
);
    typedef enum logic [2:0] {IDLE, VICTIM, WB_REQ, RD_REQ, RD_WAIT, FILL} state_t;

    state_t             state, state_nxt;
    logic [INDEX_W-1:0] index_q;
    logic [TAG_W-1:0]   tag_q;
    logic [1:0]         victim_q;
    logic [1:0]         victim_sel;
    logic [LINE_W-1:0]  line_q;
    logic               victim_dirty;

    // an empty way is always preferred over evicting, lowest number first
    always_comb begin
        victim_sel = !bus.way_valid_i[0] ? 2'd0 :
                     !bus.way_valid_i[1] ? 2'd1 :
                     !bus.way_valid_i[2] ? 2'd2 :
                     !bus.way_valid_i[3] ? 2'd3 : bus.plru_way_i;
        victim_dirty = bus.way_valid_i[victim_sel] & bus.way_dirty_i[victim_sel];
    end

    // state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    // request latch, victim register and returned line capture
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            index_q  <= '0;
            tag_q    <= '0;
            victim_q <= '0;
            line_q   <= '0;
        end else begin
            if (state == IDLE && bus.miss_valid_i) begin
                index_q  <= bus.miss_index_i;
                tag_q    <= bus.miss_tag_i;
                victim_q <= '0;
            end
            if (state == VICTIM) victim_q <= victim_sel;
            if (state == RD_WAIT && bus.l2_rsp_valid_i) line_q <= bus.l2_rsp_data_i;
        end
    end

    // next state and outputs; latched set and victim are hidden while idle
    always_comb begin
        state_nxt          = state;
        bus.miss_ready_o   = 1'b0;
        bus.index_o        = (state == IDLE) ? '0 : index_q;
        bus.victim_way_o   = (state == IDLE) ? '0 : victim_q;
        bus.l2_req_valid_o = 1'b0;
        bus.l2_req_write_o = 1'b0;
        bus.l2_req_addr_o  = '0;
        bus.l2_req_wdata_o = '0;
        bus.fill_valid_o   = 1'b0;
        bus.fill_tag_o     = '0;
        bus.fill_data_o    = '0;
        bus.plru_valid_o   = 1'b0;
        bus.plru_way_o     = '0;
        bus.done_o         = 1'b0;
        unique case (state)
            IDLE: begin
                bus.miss_ready_o = 1'b1;
                if (bus.miss_valid_i) state_nxt = VICTIM;
            end
            VICTIM: state_nxt = victim_dirty ? WB_REQ : RD_REQ;
            WB_REQ: begin
                bus.l2_req_valid_o = 1'b1;
                bus.l2_req_write_o = 1'b1;
                bus.l2_req_addr_o  = {bus.victim_tag_i, index_q};
                bus.l2_req_wdata_o = bus.victim_data_i;
                if (bus.l2_req_ready_i) state_nxt = RD_REQ;
            end
            RD_REQ: begin
                bus.l2_req_valid_o = 1'b1;
                bus.l2_req_addr_o  = {tag_q, index_q};
                if (bus.l2_req_ready_i) state_nxt = RD_WAIT;
            end
            RD_WAIT: if (bus.l2_rsp_valid_i) state_nxt = FILL;
            FILL: begin
                bus.fill_valid_o = 1'b1;
                bus.fill_tag_o   = tag_q;
                bus.fill_data_o  = line_q;
                bus.plru_valid_o = 1'b1;
                bus.plru_way_o   = victim_q;
                bus.done_o       = 1'b1;
                state_nxt        = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: doc/cache_miss_handler.md
# cache_miss_handler

- Sequences an L1 miss in the 4-way L1 cache: picks a victim way, posts a dirty-victim writeback to L2, fetches the missing line from L2 and issues a one-cycle fill.
- Sits between the L1 lookup stage and the L2 port.
- Consumes the tree pseudo-LRU's victim output and drives the pLRU update for the filled way.

## Interface
- INDEX_W, 4, set index width (one pLRU tree per set)
- TAG_W, 24, tag width
- LINE_W, 128, line data width
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous, active-low reset
- miss_valid_i  in  1  miss request from lookup stage
- miss_ready_o  out  1  handler idle, request accepted when valid&ready
- miss_index_i  in  INDEX_W  set of missing line
- miss_tag_i  in  TAG_W  tag of missing line
- index_o  out  INDEX_W  latched set; drives the array read port and pLRU index
- way_valid_i  in  4  valid bits of set index_o
- way_dirty_i  in  4  dirty bits of set index_o
- plru_way_i  in  2  pLRU victim for set index_o
- victim_way_o  out  2  registered victim way
- victim_tag_i  in  TAG_W  tag array read at (index_o, victim_way_o)
- victim_data_i  in  LINE_W  data array read at (index_o, victim_way_o)
- l2_req_valid_o / l2_req_ready_i  out/in  1  L2 request handshake
- l2_req_write_o  out  1  1 = writeback, 0 = line read
- l2_req_addr_o  out  TAG_W+INDEX_W  line address {tag, index}
- l2_req_wdata_o  out  LINE_W  writeback data
- l2_rsp_valid_i  in  1  read data returned (one-cycle pulse)
- l2_rsp_data_i  in  LINE_W  returned line
- fill_valid_o  out  1  one-cycle array write: way victim_way_o, set index_o
- fill_tag_o / fill_data_o  out  TAG_W / LINE_W  tag and data to write; valid set, dirty cleared
- plru_valid_o / plru_way_o  out  1 / 2  pLRU access update, asserted with fill
- done_o  out  1  miss complete pulse, coincident with fill

## Operation
- States: IDLE, VICTIM, WB_REQ, RD_REQ, RD_WAIT, FILL.
- IDLE: miss_ready_o=1. On miss_valid_i, latch index and tag, then go to VICTIM. All other outputs are 0.
- VICTIM (one cycle):
  - If any way_valid_i bit is 0, the victim is the lowest-numbered invalid way; otherwise it is plru_way_i.
  - Register the victim into victim_way_o.
  - Register dirty = way_valid_i[v] & way_dirty_i[v].
  - Next state is WB_REQ if dirty, else RD_REQ.
- WB_REQ:
  - l2_req_valid_o=1, write=1, addr={victim_tag_i, index_o}, wdata=victim_data_i.
  - The arrays are not written while the handler is busy, so these values are stable.
  - Hold until l2_req_ready_i, then go to RD_REQ. The writeback is posted (no response).
- RD_REQ: l2_req_valid_o=1, write=0, addr={latched tag, index_o}, wdata=0. Hold until ready, then go to RD_WAIT.
- RD_WAIT: wait for l2_rsp_valid_i; capture l2_rsp_data_i into the line register, then go to FILL.
- FILL (one cycle):
  - fill_valid_o=plru_valid_o=done_o=1.
  - plru_way_o=victim_way_o; fill_tag_o is the latched tag; fill_data_o is the captured line.
  - Next state is IDLE.
- l2_rsp_valid_i outside RD_WAIT is ignored.
- l2_req_valid_o, once raised, never drops before the handshake, and its payload does not change before the handshake.

## Timing
- Reset (asynchronous, immediate): state IDLE, miss_ready_o=1, all other outputs and registers 0.
- Reset mid-miss abandons the transaction: l2_req_valid_o drops at once and no fill or done pulse follows.
- Clean miss accepted at cycle T:
  - VICTIM at T+1; RD_REQ from T+2.
  - With ready=1 at T+2, RD_WAIT at T+3.
  - Response at cycle R gives FILL at R+1, and IDLE with miss_ready_o=1 at R+2.
- Dirty miss: WB_REQ at T+2; with ready at T+2, RD_REQ at T+3. Each ready stall adds one cycle.
- The earliest response in RD_WAIT is its first cycle, so the minimum clean-miss latency is T to FILL at T+4.
- A new miss can be accepted in the first IDLE cycle after FILL.

## Test plan
- Clean miss into empty set:
  - Stimulus: index 3, tag 0x0000AB, way_valid=0000; ready tied 1; response 2 cycles after the request with data 0x1111…
  - Required: victim 0, one read request addr {0x0000AB, 3}, fill way 0 with that data, plru_way_o=0, done at T+5.
- Full clean set:
  - Stimulus: valid=1111, dirty=0000, plru_way_i=2.
  - Required: victim 2, no write request, fill way 2.
- Dirty victim:
  - Stimulus: valid=1111, dirty=0100, plru_way_i=2, victim_tag=0x000055; ready low for 3 cycles on the write.
  - Required: write request with addr {0x000055, index} held stable 4 cycles, then a read request, then fill way 2.
- Invalid-way priority:
  - Stimulus: valid=1011, plru_way_i=0.
  - Required: victim 2, writeback skipped even with dirty[0]=1.
- Stray response:
  - Stimulus: l2_rsp_valid_i pulsed in IDLE and in RD_REQ.
  - Required: ignored, no fill; the fill uses only the RD_WAIT response.
- Reset mid-miss:
  - Stimulus: rst_ni low during RD_WAIT.
  - Required: l2_req_valid_o=0 and miss_ready_o=1 immediately, no done_o pulse; a subsequent miss completes normally.
